// File: rtl/mips_program_loader_pkg.sv
// ============================================================================
// Package     : mips_loader_pkg
// Description : Shared types and constants for the MIPS program loader:
//               loader state encoding, header field positions and the
//               default reset-release delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_loader_pkg;

    // Loader state encoding
    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_LOAD  = 3'd1,
        S_CHK   = 3'd2,
        S_REL   = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    // Header word layout: [31:16] word count, [15:0] base word address
    localparam int CNT_MSB  = 31;
    localparam int CNT_LSB  = 16;
    localparam int BASE_MSB = 15;
    localparam int BASE_LSB = 0;

    // Cycles cpu_reset is held after a good checksum
    localparam int DEFAULT_RELEASE_CYCLES = 3;

endpackage : mips_loader_pkg

`default_nettype wire

// File: rtl/mips_program_loader_if.sv
// ============================================================================
// Interface   : mips_program_loader_if
// Description : 32-bit valid/ready word stream feeding the program loader.
//               master : stream source (host / bench)
//               slave  : loader
// Signals     : in_valid (source->loader), in_data[31:0] (source->loader),
//               in_ready (loader->source)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_program_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface : mips_program_loader_if

`default_nettype wire

// File: rtl/mips_program_loader_write_stage.sv
// ============================================================================
// Module      : loader_write_stage
// Description : Registered memory write stage with a wrap-around word
//               address counter. A write request presented in one cycle
//               appears on we_o/addr_o/wdata_o in the next cycle.
// Ports       : clk, reset (sync, active-low)
//               base_load_i/base_i : load the write pointer with a base
//               wr_i/wdata_i       : write one word at the pointer
//               we_o/addr_o/wdata_o: registered write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_write_stage #(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              base_load_i,
    input  wire logic [ADDR_W-1:0] base_i,
    input  wire logic              wr_i,
    input  wire logic [31:0]       wdata_i,
    output logic                   we_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [31:0]            wdata_o
);

    // ptr_q is the address the next payload word goes to; addr_q holds the
    // address of the write currently presented on the port.
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            we_q <= wr_i;
            if (base_load_i) begin
                ptr_q <= base_i;
            end else if (wr_i) begin
                addr_q  <= ptr_q;
                wdata_q <= wdata_i;
                ptr_q   <= ptr_q + 1'b1;   // wraps modulo 2**ADDR_W
            end
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule : loader_write_stage

`default_nettype wire

// File: rtl/mips_program_loader.sv
// ============================================================================
// Module      : mips_program_loader
// Description : Loads a header/payload/checksum word stream into the MIPS
//               instruction and data memories (same word to same address in
//               both), then releases the core from reset after a good
//               checksum.
// Ports       : clk, reset (sync, active-low)
//               s_if       : stream slave (in_valid, in_ready, in_data)
//               imem_we, dmem_we, mem_addr, mem_wdata : memory write port
//               cpu_reset  : registered active-high core reset
//               load_done  : image loaded and core released
//               load_error : checksum mismatch
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
    parameter int CNT_W          = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_program_loader_if.slave    s_if,
    output logic                    imem_we,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    cpu_reset,
    output logic                    load_done,
    output logic                    load_error
);

    localparam int REL_W = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        sum_q,   sum_d;
    logic [REL_W-1:0]   rel_q,   rel_d;
    logic               cpu_reset_q;
    logic               load_done_q;
    logic               load_error_q;

    logic               in_ready_w;
    logic               accept_w;
    logic               wr_w;
    logic               base_load_w;
    logic               we_w;

    assign in_ready_w    = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
    assign accept_w      = s_if.in_valid && in_ready_w;
    assign s_if.in_ready = in_ready_w;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_d       = sum_q;
        rel_d       = rel_q;
        wr_w        = 1'b0;
        base_load_w = 1'b0;
        case (state_q)
            S_HDR: begin
                if (accept_w) begin
                    count_d     = s_if.in_data[CNT_LSB +: CNT_W];
                    sum_d       = '0;
                    base_load_w = 1'b1;
                    state_d     = (s_if.in_data[CNT_LSB +: CNT_W] == '0) ? S_CHK : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept_w) begin
                    wr_w    = 1'b1;
                    sum_d   = sum_q + s_if.in_data;
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept_w) begin
                    if (s_if.in_data == sum_q) begin
                        state_d = S_REL;
                        rel_d   = REL_W'(RELEASE_CYCLES);
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_REL: begin
                if (rel_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rel_d = rel_q - 1'b1;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_HDR;
        endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state and never glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_HDR;
            count_q      <= '0;
            sum_q        <= '0;
            rel_q        <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            rel_q        <= rel_d;
            cpu_reset_q  <= (state_d != S_RUN);
            load_done_q  <= (state_d == S_RUN);
            load_error_q <= (state_d == S_ERROR);
        end
    end

    loader_write_stage #(
        .ADDR_W (ADDR_W)
    ) u_write_stage (
        .clk         (clk),
        .reset       (reset),
        .base_load_i (base_load_w),
        .base_i      (s_if.in_data[BASE_LSB +: ADDR_W]),
        .wr_i        (wr_w),
        .wdata_i     (s_if.in_data),
        .we_o        (we_w),
        .addr_o      (mem_addr),
        .wdata_o     (mem_wdata)
    );

    assign imem_we    = we_w;
    assign dmem_we    = we_w;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule : mips_program_loader

`default_nettype wire

// File: tb/tb_mips_program_loader.sv
// ============================================================================
// Module      : tb_mips_program_loader
// Description : Directed self-checking bench for mips_program_loader.
//               Inputs change and outputs are sampled 1 time unit after the
//               rising edge. A small memory model captures the write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_program_loader;

    localparam int ADDR_W = 10;
    localparam int REL    = 3;

    logic              clk;
    logic              reset;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;

    int checks;
    int errors;
    int wr_cnt;

    logic [31:0] imem_m [0:(1<<ADDR_W)-1];
    logic [31:0] dmem_m [0:(1<<ADDR_W)-1];

    mips_program_loader_if lif ();

    mips_program_loader #(
        .ADDR_W         (ADDR_W),
        .RELEASE_CYCLES (REL),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_if       (lif.slave),
        .imem_we    (imem_we),
        .dmem_we    (dmem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories behind the write port
    always @(posedge clk) begin
        if (imem_we) begin
            imem_m[mem_addr] <= mem_wdata;
            wr_cnt           <= wr_cnt + 1;
        end
        if (dmem_we) dmem_m[mem_addr] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Presents one word and returns 1 time unit after the edge accepting it.
    task automatic send(input logic [31:0] w);
        int t;
        t = 0;
        lif.in_valid = 1'b1;
        lif.in_data  = w;
        while (lif.in_ready !== 1'b1 && t < 16) begin
            step();
            t++;
        end
        if (lif.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_ready got=%b exp=1", lif.in_ready);
        end else begin
            step();
        end
        lif.in_valid = 1'b0;
        lif.in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        step();
        step();
        checks++;
        if ({lif.in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=100100",
                     {lif.in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h exp 0/0", mem_addr, mem_wdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        do_reset();
        send(32'h0003_0020);
        checks++;
        if (imem_we !== 1'b0) begin
            errors++; $display("FAIL basic_hdr_we got=%b exp=0", imem_we);
        end
        for (int i = 0; i < 3; i++) begin
            send(words[i]);
            checks++;
            if (imem_we !== 1'b1 || dmem_we !== 1'b1 || mem_addr !== ADDR_W'(32'h20 + i) || mem_wdata !== words[i]) begin
                errors++;
                $display("FAIL basic_write%0d got we=%b/%b addr=%h data=%h exp 1/1 %h %h",
                         i, imem_we, dmem_we, mem_addr, mem_wdata, 32'h20 + i, words[i]);
            end
        end
        send(32'h66);
        checks++;
        if (imem_we !== 1'b0 || lif.in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_chk got we=%b rdy=%b exp 0 0", imem_we, lif.in_ready);
        end
        for (int i = 1; i <= REL + 1; i++) begin
            step();
            checks++;
            if (cpu_reset !== (i <= REL)) begin
                errors++; $display("FAIL basic_release_c%0d got=%b exp=%b", i, cpu_reset, (i <= REL));
            end
        end
        checks++;
        if (load_done !== 1'b1 || load_error !== 1'b0 || lif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b err=%b rdy=%b exp 1 0 0", load_done, load_error, lif.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_m[32'h20 + i] !== words[i] || dmem_m[32'h20 + i] !== words[i]) begin
                errors++;
                $display("FAIL basic_mem%0d got i=%h d=%h exp=%h", i, imem_m[32'h20 + i], dmem_m[32'h20 + i], words[i]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        int w0;
        do_reset();
        send(32'h0003_0020);
        send(32'h11);
        send(32'h22);
        send(32'h33);
        send(32'h67);
        w0 = wr_cnt;
        lif.in_valid = 1'b1;
        lif.in_data  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (load_error !== 1'b1 || cpu_reset !== 1'b1 || lif.in_ready !== 1'b0 ||
                load_done !== 1'b0 || imem_we !== 1'b0 || dmem_we !== 1'b0) begin
                errors++;
                $display("FAIL bad_chk_c%0d got err=%b rst=%b rdy=%b done=%b we=%b exp 1 1 0 0 0",
                         i, load_error, cpu_reset, lif.in_ready, load_done, imem_we);
            end
            step();
        end
        lif.in_valid = 1'b0;
        checks++;
        if (wr_cnt !== w0) begin
            errors++; $display("FAIL bad_chk_writes got=%0d exp=%0d", wr_cnt, w0);
        end
    endtask

    task automatic test_wrap();
        int t;
        do_reset();
        send(32'h0002_03FF);
        send(32'hAAAA_0001);
        checks++;
        if (imem_we !== 1'b1 || mem_addr !== 10'h3FF || mem_wdata !== 32'hAAAA_0001) begin
            errors++; $display("FAIL wrap_first got we=%b addr=%h data=%h exp 1 3ff aaaa0001", imem_we, mem_addr, mem_wdata);
        end
        send(32'hBBBB_0002);
        checks++;
        if (imem_we !== 1'b1 || mem_addr !== 10'h000 || mem_wdata !== 32'hBBBB_0002) begin
            errors++; $display("FAIL wrap_second got we=%b addr=%h data=%h exp 1 000 bbbb0002", imem_we, mem_addr, mem_wdata);
        end
        send(32'h6665_0003);
        t = 0;
        while (load_done !== 1'b1 && t < 12) begin step(); t++; end
        checks++;
        if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
            errors++; $display("FAIL wrap_done got done=%b rst=%b exp 1 0", load_done, cpu_reset);
        end
    endtask

    task automatic test_zero();
        int w0;
        do_reset();
        w0 = wr_cnt;
        send(32'h0000_0000);
        send(32'h0000_0000);
        checks++;
        if (imem_we !== 1'b0 || load_error !== 1'b0) begin
            errors++; $display("FAIL zero_chk got we=%b err=%b exp 0 0", imem_we, load_error);
        end
        for (int i = 1; i <= REL + 1; i++) begin
            step();
            checks++;
            if (load_done !== (i == REL + 1)) begin
                errors++; $display("FAIL zero_run_c%0d got=%b exp=%b", i, load_done, (i == REL + 1));
            end
        end
        checks++;
        if (wr_cnt !== w0) begin
            errors++; $display("FAIL zero_writes got=%0d exp=%0d", wr_cnt, w0);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] img [96];
        logic [31:0] sum;
        int gap;
        int t;
        sum = '0;
        // Representative instruction/data words of a small sort program
        for (int i = 0; i < 96; i++) begin
            img[i] = (32'h2408_0000 + 32'(i) * 32'h0001_0107) ^ (32'(i) << 21);
            sum    = sum + img[i];
        end
        do_reset();
        send(32'h0060_0100);
        for (int i = 0; i < 96; i++) begin
            send(img[i]);
            checks++;
            if (imem_we !== 1'b1 || mem_addr !== ADDR_W'(32'h100 + i) || mem_wdata !== img[i]) begin
                errors++;
                $display("FAIL gaps_write%0d got we=%b addr=%h data=%h exp 1 %h %h",
                         i, imem_we, mem_addr, mem_wdata, 32'h100 + i, img[i]);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                lif.in_data = $urandom;
                step();
                checks++;
                if (imem_we !== 1'b0 || dmem_we !== 1'b0) begin
                    errors++; $display("FAIL gaps_idle%0d got we=%b/%b exp 0/0", i, imem_we, dmem_we);
                end
            end
        end
        send(sum);
        t = 0;
        while (load_done !== 1'b1 && t < 12) begin step(); t++; end
        checks++;
        if (load_done !== 1'b1) begin
            errors++; $display("FAIL gaps_done got=%b exp=1", load_done);
        end
        for (int i = 0; i < 96; i++) begin
            checks++;
            if (imem_m[32'h100 + i] !== img[i] || dmem_m[32'h100 + i] !== img[i]) begin
                errors++;
                $display("FAIL gaps_mem%0d got i=%h d=%h exp=%h", i, imem_m[32'h100 + i], dmem_m[32'h100 + i], img[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int t;
        do_reset();
        send(32'h0005_0040);
        send(32'hA1);
        send(32'hA2);
        reset = 1'b0;
        step();
        checks++;
        if ({lif.in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error} !== 6'b100100) begin
            errors++;
            $display("FAIL midrst_ctrl got=%b exp=100100",
                     {lif.in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL midrst_bus got addr=%h data=%h exp 0/0", mem_addr, mem_wdata);
        end
        reset = 1'b1;
        send(32'h0002_0050);
        send(32'h5);
        send(32'h6);
        send(32'hB);
        t = 0;
        while (load_done !== 1'b1 && t < 12) begin step(); t++; end
        checks++;
        if (load_done !== 1'b1 || cpu_reset !== 1'b0 || load_error !== 1'b0) begin
            errors++; $display("FAIL midrst_reload got done=%b rst=%b err=%b exp 1 0 0", load_done, cpu_reset, load_error);
        end
        checks++;
        if (imem_m[32'h50] !== 32'h5 || imem_m[32'h51] !== 32'h6 || dmem_m[32'h51] !== 32'h6) begin
            errors++; $display("FAIL midrst_mem got %h %h exp 5 6", imem_m[32'h50], imem_m[32'h51]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_cnt = 0;
        reset  = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_wrap();
        test_zero();
        test_gaps();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_mips_program_loader

`default_nettype wire

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Hardware image loader that writes a program and data image into the pipelined MIPS instruction and data memories, then releases the core from reset.
- Consumes a 32-bit valid/ready word stream: one header word, N payload words, one checksum word.
- Each payload word is written to the same word address in both memories, so one image serves code and data.
- Sits between the host/bench stream source and the pipelined_mips memory write ports and reset pin. It replaces $readmemh preloading.

Parameters:
ADDR_W, 10, word-address width of each memory (depth 2**ADDR_W)
RELEASE_CYCLES, 3, cycles cpu_reset stays high after a good checksum
CNT_W, 16, width of the header word-count field (must be <= 16)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  stream word valid
in_ready  out  1  loader accepts word this cycle
in_data  in  32  stream word
imem_we  out  1  instruction-memory write enable
dmem_we  out  1  data-memory write enable
mem_addr  out  ADDR_W  shared word address for both memories
mem_wdata  out  32  shared write data
cpu_reset  out  1  active-high reset driven to pipelined_mips
load_done  out  1  high from entry to RUN until reset
load_error  out  1  high from entry to ERROR until reset

Behaviour:
- Beat accepted when in_valid && in_ready on a rising edge. in_data is ignored otherwise.
- Reset (reset==0 at an edge), with values visible after that edge:
  - state=HDR, in_ready=1, imem_we=dmem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, load_done=0, load_error=0, count=0, sum=0.
- Reset mid-load aborts at once with the same values. Memory contents already written are not rolled back.
- Header word: [31:16]=word count N (CNT_W bits), [15:0]=base word address. Base is truncated to ADDR_W bits.
- HDR: in_ready=1. On accept, latch N and base and clear sum. If N==0 go to CHK, else go to LOAD.
- LOAD: in_ready=1. On each accept:
  - Registered write, so the next cycle sees imem_we=dmem_we=1, mem_addr=current address, mem_wdata=word.
  - Address increments by 1 modulo 2**ADDR_W (wraps silently).
  - sum += word (mod 2**32); remaining count decrements.
  - The beat carrying the last word moves to CHK.
- No accepted beat in a cycle means both write enables are 0 in the next cycle. in_valid gaps are legal anywhere.
- CHK: in_ready=1. The accepted word is compared with sum.
  - Equal: go to REL and load the release counter with RELEASE_CYCLES.
  - Unequal: go to ERROR.
- The last payload write and the CHK accept never overlap a pending write, so the write path is a single register stage.
- REL: in_ready=0, cpu_reset=1. Counter decrements every cycle; go to RUN when it reaches 0. RELEASE_CYCLES=0 goes to RUN on the next cycle.
- RUN: in_ready=0, cpu_reset=0, load_done=1. Terminal until reset.
- ERROR: in_ready=0, cpu_reset=1, load_error=1. Terminal until reset.
- load_done and load_error are never both 1.
- cpu_reset is a registered output, glitch-free, and deasserts exactly RELEASE_CYCLES+1 cycles after the checksum accept edge.
- Latency: each payload word is written 1 cycle after its accept. Throughput is 1 word/cycle.

Decomposition:
- Shared package mips_loader_pkg holds:
  - state enum (HDR, LOAD, CHK, REL, RUN, ERROR)
  - header field positions: CNT_MSB=31, CNT_LSB=16, BASE_MSB=15, BASE_LSB=0
  - default RELEASE_CYCLES
- One natural sub-module, loader_write_stage: the registered address/data/enable stage with the wrap-around address counter. The FSM and checksum stay in the top.

Test Plan:
- Header 0x0003_0020, words 0x11,0x22,0x33, checksum 0x66 with continuous valid:
  - writes land at addr 0x20/0x21/0x22, each 1 cycle after its accept
  - cpu_reset falls 4 cycles after the checksum accept; load_done=1
- Same image with checksum 0x67: load_error=1, cpu_reset stays 1, in_ready=0, no further writes.
- Header 0x0002_03FF (ADDR_W=10), words A,B, correct checksum: writes at 0x3FF then 0x000 (wrap).
- Header 0x0000_0000 then checksum 0: no writes; RUN reached after RELEASE_CYCLES+1 cycles.
- Random in_valid gaps across a 96-word isort32 image: memory matches the image word-for-word and no write occurs in a gap cycle.
- reset=0 for one edge after 2 of 5 payload words:
  - all outputs return to reset values; cpu_reset=1
  - a fresh full image then loads and runs correctly
